// File: rtl/rv_wb_pkg.sv
// Shared widths and the write-back entry type for the integer register-file
// write path.
package rv_wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO holding load results that lost arbitration for the
// register-file write port. Head entry is presented combinationally.
module wb_result_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Single write-port master for the integer register file: ALU results first,
// then buffered loads in acceptance order, plus the pending-load scoreboard.
module reg_writeback_arbiter
  import rv_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              hazard,
  output logic              reg_wr,
  output logic [REG_AW-1:0] waddr,
  output logic [XLEN-1:0]   wdata
);

  wb_entry_t        fifo_head;
  wb_entry_t        sel_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             mem_xfer;
  logic             bypass;
  logic             sel_valid;
  logic             load_sel;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;

  assign mem_ready = !fifo_full;
  assign mem_xfer  = mem_valid && mem_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    load_sel  = 1'b0;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: alu_rd, data: alu_data};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = fifo_head;
      load_sel  = 1'b1;
      fifo_pop  = 1'b1;
    end else if (mem_xfer) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: mem_rd, data: mem_data};
      load_sel  = 1'b1;
      bypass    = 1'b1;
    end
  end

  // Any accepted load that did not go straight to the port joins the tail.
  assign fifo_push = mem_xfer && !bypass;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ('{rd: mem_rd, data: mem_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_wr <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      reg_wr <= sel_valid && (sel_entry.rd != '0);
      if (sel_valid) begin
        waddr <= sel_entry.rd;
        wdata <= sel_entry.data;
      end
    end
  end

  // Clear before set so a reissue in the retire cycle keeps the flag.
  always_comb begin
    pending_nxt = pending;
    if (load_sel) pending_nxt[sel_entry.rd] = 1'b0;
    if (ld_issue) pending_nxt[ld_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

  a_mem_rd_pending : assert property (@(posedge clk) disable iff (reset)
    (mem_valid && mem_ready && mem_rd != '0) |-> pending[mem_rd]);

  a_issue_not_pending : assert property (@(posedge clk) disable iff (reset)
    (ld_issue && ld_rd != '0 && pending[ld_rd]) |-> (load_sel && sel_entry.rd == ld_rd));

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts register writes,
// a negedge monitor pops and compares whenever reg_wr is presented.
module tb_reg_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, ld_issue = 1'b0;
  logic [4:0]  alu_rd = '0, mem_rd = '0, ld_rd = '0;
  logic [4:0]  chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        mem_ready, hazard, reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  reg_writeback_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  int   tests = 0;
  int   fails = 0;
  ent_t loadq[$];
  ent_t expq[$];
  bit   pend_m[32];
  logic [4:0] outst[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && reg_wr === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got x%0d=%0h, required no write at %0t", waddr, wdata, $time);
      end else begin
        ent_t e;
        e = expq.pop_front();
        check("wb_addr", waddr, e.rd);
        check("wb_data", wdata, e.d);
      end
    end
  end

  // One clock of stimulus; the model works purely on queues of results.
  task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input bit li, input logic [4:0] lr,
                       input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] c3,
                       output bit acc);
    bit   rdy, have;
    ent_t w;
    @(posedge clk);
    #1;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    ld_issue = li;  ld_rd = lr;
    chk_rs1 = c1;   chk_rs2 = c2; chk_rd = c3;
    #1;
    rdy = (loadq.size() < 4);
    check("mem_ready", mem_ready, rdy);
    check("hazard", hazard, pend_m[c1] | pend_m[c2] | pend_m[c3]);
    acc = mv && rdy;
    if (acc) loadq.push_back('{mr, md});
    have = 1'b0;
    if (av) begin
      w = '{ar, ad};
      have = 1'b1;
    end else if (loadq.size() > 0) begin
      w = loadq.pop_front();
      have = 1'b1;
      pend_m[w.rd] = 1'b0;
    end
    if (li) pend_m[lr] = 1'b1;
    pend_m[0] = 1'b0;
    if (have && w.rd != 0) expq.push_back(w);
  endtask

  task automatic idle(input logic [4:0] c);
    bit a;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, c, c, c, a);
  endtask

  task automatic issue(input logic [4:0] r);
    bit a;
    cycle(0, 0, 0, 0, 0, 0, 1, r, 0, 0, 0, a);
  endtask

  // Deliver every outstanding load with no ALU traffic, then let writes land.
  task automatic drain();
    bit a;
    for (int i = 0; i < 200 && (outst.size() > 0 || loadq.size() > 0); i++) begin
      if (outst.size() > 0) begin
        cycle(0, 0, 0, 1, outst[0], $urandom, 0, 0, 0, 0, 0, a);
        if (a) void'(outst.pop_front());
      end else begin
        idle(0);
      end
    end
    idle(0); idle(0); idle(0);
    check("drain_empty", expq.size(), 0);
    check("drain_loads", loadq.size() + outst.size(), 0);
  endtask

  initial begin
    bit a;
    int idx;
    #23 reset = 1'b0;
    #1;
    check("rst_reg_wr", reg_wr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_hazard", hazard, 0);

    // 1: lone ALU write
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5, 5, a);
    idle(5); idle(5);

    // 2: ALU/load collision
    issue(7);
    cycle(1, 3, 32'h33, 1, 7, 32'h11, 0, 0, 0, 0, 0, a);
    check("collide_acc", a, 1);
    idle(0); idle(0); idle(0);

    // 3: backpressure, loads x8..x13 behind a 6-cycle ALU burst
    for (int r = 8; r < 14; r++) issue(5'(r));
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5'(20 + i), $urandom, idx < 6, 5'(8 + idx), 32'h100 + idx, 0, 0, 0, 0, 0, a);
      if (a) idx++;
    end
    check("bp_accepted", idx, 4);
    for (int i = 0; i < 20 && idx < 6; i++) begin
      cycle(0, 0, 0, 1, 5'(8 + idx), 32'h100 + idx, 0, 0, 0, 0, 0, a);
      if (a) idx++;
    end
    check("bp_all_in", idx, 6);
    drain();

    // 4: scoreboard set/clear and reissue in the clear cycle
    issue(9);
    idle(9);
    cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0, a);
    idle(9); idle(9);
    issue(9);
    cycle(0, 0, 0, 1, 9, 32'h98, 1, 9, 0, 9, 0, a);
    idle(9); idle(9);
    outst.push_back(9);
    drain();

    // 5: x0 never written, never pending
    issue(0);
    cycle(1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 1, 0, 0, 0, 0, a);
    idle(0); idle(0); idle(0);
    check("x0_fifo_drained", mem_ready, 1);

    // 6: async reset with three buffered loads and x4 pending
    issue(4); issue(5); issue(6);
    for (int i = 0; i < 3; i++)
      cycle(1, 5'(16 + i), $urandom, 1, 5'(4 + i), $urandom, 0, 0, 0, 0, 0, a);
    #1;
    alu_valid = 0; mem_valid = 0; ld_issue = 0;
    chk_rs1 = 4; chk_rs2 = 4; chk_rd = 4;
    reset = 1'b1;
    #1;
    expq.delete(); loadq.delete(); outst.delete();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    check("arst_reg_wr", reg_wr, 0);
    check("arst_waddr", waddr, 0);
    check("arst_wdata", wdata, 0);
    check("arst_hazard", hazard, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    idle(4); idle(4); idle(4); idle(4);

    // Random traffic obeying the load protocol
    for (int i = 0; i < 400; i++) begin
      bit av, mv, li;
      logic [4:0] lr;
      av = ($urandom_range(0, 2) == 0);
      mv = (outst.size() > 0) && ($urandom_range(0, 1) == 1);
      lr = 5'($urandom_range(0, 31));
      li = ($urandom_range(0, 2) == 0) && !pend_m[lr];
      cycle(av, 5'($urandom), $urandom, mv, mv ? outst[0] : 5'($urandom), $urandom,
            li, lr, 5'($urandom), 5'($urandom), 5'($urandom), a);
      if (a) void'(outst.pop_front());
      if (li) outst.push_back(lr);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish before 200000");
    $fatal(1);
  end

endmodule
